// File: rtl/elevator_call_latch_if.sv
// Button, sensor and lamp bundle for elevator_call_latch.
// Handshake: none. Every signal is a level sampled on the rising clk edge.
// The master drives the raw buttons and feedback, and the slave returns lamps and summary.
// last_dir_dbg exposes the latch's direction-memory state.
interface elevator_call_latch_if;
    logic       u1, u2, d2, d3;
    logic       f1, f2, f3;
    logic [1:0] fs;
    logic       door;
    logic [1:0] dir;
    logic       u1_q, u2_q, d2_q, d3_q, f1_q, f2_q, f3_q;
    logic       req_above, req_below, req_here, any_req;
    logic [1:0] last_dir_dbg;

    modport master (
        output u1, u2, d2, d3, f1, f2, f3, fs, door, dir,
        input  u1_q, u2_q, d2_q, d3_q, f1_q, f2_q, f3_q,
        input  req_above, req_below, req_here, any_req, last_dir_dbg
    );

    modport slave (
        input  u1, u2, d2, d3, f1, f2, f3, fs, door, dir,
        output u1_q, u2_q, d2_q, d3_q, f1_q, f2_q, f3_q,
        output req_above, req_below, req_here, any_req, last_dir_dbg
    );
endinterface

// File: rtl/elevator_call_latch.sv
// elevator_call_latch: debounces hall and car buttons and latches them as pending requests.
// It clears requests as the car serves them and summarises the pending requests relative to the current floor.
// Optional macro CALL_CANCEL_EN: a repeat accepted press on a pending car button cancels it.
module elevator_call_latch #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int CNT_W           = 4
) (
    input logic            clk,
    input logic            rst,
    elevator_call_latch_if.slave bus
);
    typedef enum logic [1:0] {
        DIR_NONE = 2'b00,
        DIR_UP   = 2'b01,
        DIR_DOWN = 2'b10
    } dir_e;

    localparam int NB   = 7;
    localparam int B_U1 = 0;
    localparam int B_U2 = 1;
    localparam int B_D2 = 2;
    localparam int B_D3 = 3;
    localparam int B_F1 = 4;
    localparam int B_F2 = 5;
    localparam int B_F3 = 6;
    localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic [NB-1:0]    raw;
    logic [NB-1:0]    accept;
    logic [NB-1:0]    clr;
    logic [NB-1:0]    pend_q, pend_d;
    logic [NB-1:0]    armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q [NB];
    logic [CNT_W-1:0] cnt_d [NB];
    dir_e             dir_q, dir_d;
    logic             r1, r2, r3;
    logic             at_f1, at_f2, at_f3;

    assign raw = {bus.f3, bus.f2, bus.f1, bus.d3, bus.d2, bus.u2, bus.u1};

    // Requests grouped by floor, taken from the registered pending bits
    assign r1 = pend_q[B_U1] | pend_q[B_F1];
    assign r2 = pend_q[B_U2] | pend_q[B_D2] | pend_q[B_F2];
    assign r3 = pend_q[B_D3] | pend_q[B_F3];

    // A floor is being served while the car sits there with the door open
    assign at_f1 = (bus.fs == 2'b01) && !bus.door;
    assign at_f2 = (bus.fs == 2'b10) && !bus.door;
    assign at_f3 = (bus.fs == 2'b11) && !bus.door;

    // Debounce: count consecutive high samples and accept once per press while armed
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            cnt_d[i]   = '0;
            armed_d[i] = 1'b1;
            accept[i]  = 1'b0;
            if (raw[i]) begin
                cnt_d[i]   = (cnt_q[i] == DB_MAX) ? DB_MAX : cnt_q[i] + CNT_W'(1);
                accept[i]  = armed_q[i] && (cnt_d[i] == DB_MAX);
                armed_d[i] = armed_q[i] && !accept[i];
            end
        end
    end

    // Direction memory: follows up/down motion; idle and illegal codes keep the old value
    always_comb begin
        dir_d = dir_q;
        case (bus.dir)
            2'b01:   dir_d = DIR_UP;
            2'b10:   dir_d = DIR_DOWN;
            default: dir_d = dir_q;
        endcase
    end

    // Service clears; at F2 the direction decides which hall call is served
    always_comb begin
        clr = '0;
        if (at_f1) begin
            clr[B_U1] = 1'b1;
            clr[B_F1] = 1'b1;
        end
        if (at_f3) begin
            clr[B_D3] = 1'b1;
            clr[B_F3] = 1'b1;
        end
        if (at_f2) begin
            clr[B_F2] = 1'b1;
            case (dir_q)
                DIR_UP: begin
                    clr[B_U2] = 1'b1;
                    clr[B_D2] = !r3;
                end
                DIR_DOWN: begin
                    clr[B_D2] = 1'b1;
                    clr[B_U2] = !r1;
                end
                default: begin
                    clr[B_U2] = 1'b1;
                    clr[B_D2] = 1'b1;
                end
            endcase
        end
    end

    // Pending update: an accepted press sets the bit and a clear always wins
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            pend_d[i] = pend_q[i];
            if (accept[i]) begin
`ifdef CALL_CANCEL_EN
                pend_d[i] = (i >= B_F1) ? !pend_q[i] : 1'b1;
`else
                pend_d[i] = 1'b1;
`endif
            end
            if (clr[i]) begin
                pend_d[i] = 1'b0;
            end
        end
    end

    // State registers; reset leaves buttons unarmed so a press held through reset is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q  <= '0;
            armed_q <= '0;
            dir_q   <= DIR_NONE;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            pend_q  <= pend_d;
            armed_q <= armed_d;
            dir_q   <= dir_d;
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Floor summary relative to the sensor; between floors only any_req is meaningful
    always_comb begin
        bus.req_above = 1'b0;
        bus.req_below = 1'b0;
        bus.req_here  = 1'b0;
        case (bus.fs)
            2'b01: begin
                bus.req_above = r2 | r3;
                bus.req_here  = r1;
            end
            2'b10: begin
                bus.req_above = r3;
                bus.req_below = r1;
                bus.req_here  = r2;
            end
            2'b11: begin
                bus.req_below = r1 | r2;
                bus.req_here  = r3;
            end
            default: begin
                bus.req_above = 1'b0;
            end
        endcase
    end

    assign bus.u1_q         = pend_q[B_U1];
    assign bus.u2_q         = pend_q[B_U2];
    assign bus.d2_q         = pend_q[B_D2];
    assign bus.d3_q         = pend_q[B_D3];
    assign bus.f1_q         = pend_q[B_F1];
    assign bus.f2_q         = pend_q[B_F2];
    assign bus.f3_q         = pend_q[B_F3];
    assign bus.any_req      = |pend_q;
    assign bus.last_dir_dbg = dir_q;
endmodule

// File: tb/tb_elevator_call_latch.sv
// Testbench for elevator_call_latch: directed scenarios followed by randomized traffic.
// The reference model works per floor, using run lengths of high samples.
module tb_elevator_call_latch;
    localparam int D   = 2;
    localparam int W   = 11;
    localparam int U1  = 0;
    localparam int U2  = 1;
    localparam int D2  = 2;
    localparam int D3  = 3;
    localparam int F1  = 4;
    localparam int F2  = 5;
    localparam int F3  = 6;

    logic       clk;
    logic       rst;
    logic [6:0] btn;
    logic [1:0] fs_v;
    logic       door_v;
    logic [1:0] dir_v;

    int n_tests;
    int n_fail;
    int cyc;

    // reference model state
    int         run_len [7];
    bit         seen_low[7];
    bit         pend    [7];
    int         m_dir;          // 0 none, 1 up, 2 down
    logic [W-1:0] exp_q[$];

    elevator_call_latch_if bus();

    elevator_call_latch #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive();
        bus.u1   = btn[U1];
        bus.u2   = btn[U2];
        bus.d2   = btn[D2];
        bus.d3   = btn[D3];
        bus.f1   = btn[F1];
        bus.f2   = btn[F2];
        bus.f3   = btn[F3];
        bus.fs   = fs_v;
        bus.door = door_v;
        bus.dir  = dir_v;
    endtask

    function automatic logic [W-1:0] observed();
        return {bus.u1_q, bus.u2_q, bus.d2_q, bus.d3_q, bus.f1_q, bus.f2_q, bus.f3_q,
                bus.req_above, bus.req_below, bus.req_here, bus.any_req};
    endfunction

    function automatic int floor_of(input int b);
        if (b == U1 || b == F1) return 1;
        if (b == D3 || b == F3) return 3;
        return 2;
    endfunction

    // Model of one clock edge, then push the expected output vector
    task automatic model_edge();
        bit          clr[7];
        bit          acc[7];
        bit          has[4];
        int          served;
        int          cur;
        logic [W-1:0] e;
        if (rst) begin
            for (int i = 0; i < 7; i++) begin
                run_len[i]  = 0;
                seen_low[i] = 1'b0;
                pend[i]     = 1'b0;
            end
            m_dir = 0;
        end else begin
            for (int k = 0; k < 4; k++) has[k] = 1'b0;
            for (int i = 0; i < 7; i++) if (pend[i]) has[floor_of(i)] = 1'b1;
            served = (!door_v && fs_v != 2'b00) ? int'(fs_v) : 0;
            for (int i = 0; i < 7; i++) clr[i] = 1'b0;
            if (served != 0) begin
                for (int i = 0; i < 7; i++) begin
                    if (floor_of(i) == served && served != 2) clr[i] = 1'b1;
                end
                if (served == 2) begin
                    clr[F2] = 1'b1;
                    clr[U2] = (m_dir != 2) || !has[1];
                    clr[D2] = (m_dir != 1) || !has[3];
                end
            end
            for (int i = 0; i < 7; i++) begin
                acc[i] = 1'b0;
                if (btn[i]) begin
                    run_len[i]++;
                    acc[i] = (run_len[i] == D) && seen_low[i];
                end else begin
                    run_len[i]  = 0;
                    seen_low[i] = 1'b1;
                end
            end
            for (int i = 0; i < 7; i++) begin
                if (clr[i]) pend[i] = 1'b0;
                else if (acc[i]) begin
`ifdef CALL_CANCEL_EN
                    if (i >= F1 && pend[i]) pend[i] = 1'b0;
                    else pend[i] = 1'b1;
`else
                    pend[i] = 1'b1;
`endif
                end
            end
            if (dir_v == 2'b01) m_dir = 1;
            else if (dir_v == 2'b10) m_dir = 2;
        end
        for (int k = 0; k < 4; k++) has[k] = 1'b0;
        for (int i = 0; i < 7; i++) if (pend[i]) has[floor_of(i)] = 1'b1;
        cur = int'(fs_v);
        e = '0;
        e[10] = pend[U1]; e[9] = pend[U2]; e[8] = pend[D2]; e[7] = pend[D3];
        e[6]  = pend[F1]; e[5] = pend[F2]; e[4] = pend[F3];
        if (cur != 0) begin
            for (int k = 1; k <= 3; k++) begin
                if (k > cur && has[k]) e[3] = 1'b1;
                if (k < cur && has[k]) e[2] = 1'b1;
            end
            e[1] = has[cur];
        end
        e[0] = has[1] | has[2] | has[3];
        exp_q.push_back(e);
    endtask

    // scoreboard: compare the oldest expected vector against the DUT
    task automatic score();
        logic [W-1:0] e;
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val("outputs", 32'(observed()), 32'(e));
        end
    endtask

    task automatic step();
        drive();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        score();
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        btn     = '0;
        fs_v    = 2'b01;
        door_v  = 1'b1;
        dir_v   = 2'b00;
        rst     = 1'b1;
        hold(2);
        check_val("reset_outputs", 32'(observed()), 32'd0);
        rst = 1'b0;
        step();

        // single press accepted on the second edge
        btn[F2] = 1'b1;
        step();
        check_val("f2_edge1", 32'(bus.f2_q), 32'd0);
        step();
        check_val("f2_edge2", 32'(bus.f2_q), 32'd1);
        check_val("f2_above", 32'(bus.req_above), 32'd1);
        check_val("f2_below", 32'(bus.req_below), 32'd0);
        step();
        btn[F2] = 1'b0;
        step();
        btn[F3] = 1'b1;
        step();
        btn[F3] = 1'b0;
        step();
        check_val("f3_short_press", 32'(bus.f3_q), 32'd0);

        // going up through F2 keeps d2 while F3 is still wanted
        btn[D2] = 1'b1;
        btn[F3] = 1'b1;
        hold(2);
        btn = '0;
        step();
        check_val("d2_set", 32'(bus.d2_q), 32'd1);
        check_val("f3_set", 32'(bus.f3_q), 32'd1);
        fs_v  = 2'b10;
        dir_v = 2'b01;
        step();
        dir_v  = 2'b00;
        door_v = 1'b0;
        step();
        check_val("up_f2_cleared", 32'(bus.f2_q), 32'd0);
        check_val("up_d2_held", 32'(bus.d2_q), 32'd1);
        check_val("up_u2_idle", 32'(bus.u2_q), 32'd0);
        fs_v = 2'b11;
        step();
        check_val("f3_served", 32'(bus.f3_q), 32'd0);
        check_val("f3_below", 32'(bus.req_below), 32'd1);

        // going down through F2 with nothing at F1 clears both hall calls
        door_v = 1'b1;
        fs_v   = 2'b10;
        dir_v  = 2'b10;
        step();
        dir_v   = 2'b00;
        btn[U2] = 1'b1;
        hold(2);
        btn = '0;
        step();
        check_val("u2_set", 32'(bus.u2_q), 32'd1);
        door_v = 1'b0;
        step();
        check_val("down_u2_cleared", 32'(bus.u2_q), 32'd0);
        check_val("down_d2_cleared", 32'(bus.d2_q), 32'd0);

        // press during service never latches
        btn[F2] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_val("clear_wins", 32'(bus.f2_q), 32'd0);
        end
        btn[F2] = 1'b0;
        door_v  = 1'b1;
        step();
        btn[U1] = 1'b1;
        hold(2);
        btn = '0;
        step();
        check_val("u1_set", 32'(bus.u1_q), 32'd1);
        fs_v   = 2'b00;
        door_v = 1'b0;
        step();
        check_val("between_u1_held", 32'(bus.u1_q), 32'd1);
        check_val("between_here", 32'(bus.req_here), 32'd0);
        check_val("between_any", 32'(bus.any_req), 32'd1);

        // repeat press on a pending car call versus a hall call
        fs_v   = 2'b01;
        door_v = 1'b1;
        btn[F3] = 1'b1; hold(2); btn[F3] = 1'b0; step();
        check_val("f3_first", 32'(bus.f3_q), 32'd1);
        btn[F3] = 1'b1; hold(2); btn[F3] = 1'b0; step();
`ifdef CALL_CANCEL_EN
        check_val("f3_cancel", 32'(bus.f3_q), 32'd0);
`else
        check_val("f3_repeat", 32'(bus.f3_q), 32'd1);
`endif
        btn[D3] = 1'b1; hold(2); btn[D3] = 1'b0; step();
        check_val("d3_first", 32'(bus.d3_q), 32'd1);
        btn[D3] = 1'b1; hold(2); btn[D3] = 1'b0; step();
        check_val("d3_repeat", 32'(bus.d3_q), 32'd1);

        // randomized traffic, with occasional resets
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 7; i++) begin
                if ($urandom_range(0, 3) == 0) btn[i] = ~btn[i];
            end
            if ($urandom_range(0, 3) == 0) fs_v = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) door_v = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) dir_v = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
